// File: rtl/spi_pattern_pkg.sv
// Shared definitions for the SPI pattern transmitter: mode encoding, default
// LFSR taps and the internal reset-release synchroniser depth.
package spi_pattern_pkg;

  // Pattern register update selected by the mode input.
  typedef enum logic [1:0] {
    ROTATE   = 2'd0,
    SHIFT_IN = 2'd1,
    LFSR     = 2'd2,
    HOLD     = 2'd3
  } spi_mode_e;

  // Maximal-length feedback for an 8-bit Fibonacci LFSR (period 255).
  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

  // Reset is asserted asynchronously and released through this many flops.
  localparam int unsigned RST_SYNC_STAGES = 2;

  // Bit counter width able to hold 0..width-1, never narrower than one bit.
  function automatic int unsigned bit_cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Programmable divider producing a single-cycle tick every div_val+1 enabled
// clk cycles. The compare is ">=" so lowering div_val below the running count
// fires a tick immediately instead of waiting for the counter to wrap.
module clk_div_tick import spi_pattern_pkg::*; #(
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = en & (cnt_q >= div_val);

  // Next count: frozen while disabled, back to zero on a tick.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Divider counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_pattern_tx.sv
// SPI-style pattern transmitter. A WIDTH-bit pattern register is shifted out
// MSB first on sdo; shifts happen on the sclk falling edge so sdo is stable at
// every sclk rising edge. frame pulses for one clk after each WIDTH-bit group.
//
// Build option: define SPI_PATTERN_LFSR_EN to compile in the LFSR mode (mode
// 2). Without it mode 2 rotates like mode 0 and TAPS has no effect.
//
// Reset asserts asynchronously; its release passes through RST_SYNC_STAGES
// flops, so the first sclk tick lands div_val+1 cycles after that internal
// release (RST_SYNC_STAGES+div_val+1 clk edges after rst falls).
module spi_pattern_tx import spi_pattern_pkg::*; #(
  parameter int unsigned       WIDTH = 8,  // 2..32
  parameter int unsigned       DIV_W = 24,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(DEFAULT_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic             sclk,
  output logic             sdo,
  output logic             frame
);

  localparam int unsigned        BitCntW   = bit_cnt_width(WIDTH);
  localparam logic [BitCntW-1:0] BitCntMax = BitCntW'(WIDTH - 1);

  logic [RST_SYNC_STAGES-1:0] rst_sync_q;
  logic                       rst_hold;
  logic                       run;
  logic                       tick;
  logic                       shift_edge;

  logic               sclk_q;
  logic               sclk_d;
  logic [WIDTH-1:0]   sr_q;
  logic [WIDTH-1:0]   sr_d;
  logic [WIDTH-1:0]   sr_shift;
  logic [BitCntW-1:0] bit_cnt_q;
  logic [BitCntW-1:0] bit_cnt_d;
  logic               frame_q;
  logic               frame_d;

  // Reset release synchroniser: set immediately by rst, drains to 0 on clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_q <= '1;
    end else begin
      rst_sync_q <= {rst_sync_q[RST_SYNC_STAGES-2:0], 1'b0};
    end
  end

  // Registers stay in their reset state until the release has propagated.
  assign rst_hold = rst_sync_q[RST_SYNC_STAGES-1];
  assign run      = en & ~rst_hold;

  clk_div_tick #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .en      (run),
    .div_val (div_val),
    .tick    (tick)
  );

  // A shift is the tick on which sclk falls.
  assign shift_edge = tick & sclk_q;

  // Candidate pattern value for the current mode, used only on a shift edge.
  always_comb begin
    sr_shift = sr_q;
    case (spi_mode_e'(mode))
      ROTATE:   sr_shift = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
      SHIFT_IN: sr_shift = {sr_q[WIDTH-2:0], ser_in};
`ifdef SPI_PATTERN_LFSR_EN
      // All-zero is the LFSR lock-up state; kick it into the sequence.
      LFSR: begin
        if (sr_q == '0) begin
          sr_shift = WIDTH'(1);
        end else begin
          sr_shift = {sr_q[WIDTH-2:0], ^(sr_q & TAPS)};
        end
      end
`else
      LFSR:     sr_shift = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
`endif
      HOLD:     sr_shift = sr_q;
      default:  sr_shift = sr_q;
    endcase
  end

`ifndef SPI_PATTERN_LFSR_EN
  // TAPS only matters when the LFSR mode is compiled in.
  logic unused_taps;
  assign unused_taps = ^TAPS;
`endif

  // Next state for sclk, pattern register, bit counter and frame strobe.
  always_comb begin
    sclk_d    = sclk_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = 1'b0;
    if (rst_hold) begin
      sclk_d    = 1'b0;
      sr_d      = '1;
      bit_cnt_d = '0;
    end else begin
      if (tick) begin
        sclk_d = ~sclk_q;
      end
      // Load wins over a shift but leaves the divider and sclk running.
      if (load) begin
        sr_d      = load_data;
        bit_cnt_d = '0;
      end else if (shift_edge) begin
        sr_d = sr_shift;
        if (bit_cnt_q == BitCntMax) begin
          bit_cnt_d = '0;
          frame_d   = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
    end
  end

  // State registers; reset leaves the pattern all ones so sdo idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q    <= 1'b0;
      sr_q      <= '1;
      bit_cnt_q <= '0;
      frame_q   <= 1'b0;
    end else begin
      sclk_q    <= sclk_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
    end
  end

  assign sclk  = sclk_q;
  assign sdo   = sr_q[WIDTH-1];
  // Disabling the block also masks a pending frame strobe.
  assign frame = frame_q & en;

endmodule

// File: tb/tb_spi_pattern_tx.sv
// Bench for spi_pattern_tx. Stimulus pushes the expected content of each
// frame (bits shifted out on sdo, shift count, spacing from the previous
// frame) into a queue; a monitor rebuilds each frame from sdo/sclk and pops
// one entry per frame pulse.
module tb_spi_pattern_tx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             ser_in;
  logic             sclk;
  logic             sdo;
  logic             frame;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    int         tag;
    int         gap;      // clk edges since previous frame, -1 = don't care
    bit         word_dc;
    logic [7:0] word;     // sdo bits shifted out during the frame, MSB first
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  spi_pattern_tx #(
    .WIDTH (WIDTH),
    .DIV_W (DIV_W),
    .TAPS  (8'hB8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_val   (div_val),
    .mode      (mode),
    .load      (load),
    .load_data (load_data),
    .ser_in    (ser_in),
    .sclk      (sclk),
    .sdo       (sdo),
    .frame     (frame)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int tag, input logic [7:0] word, input bit dc, input int gap);
    exp_t e;
    e.tag     = tag;
    e.word    = word;
    e.word_dc = dc;
    e.gap     = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d pending frames required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_fall(input string name, output bit ok);
    logic p;
    p  = sclk;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (p && !sclk) begin
        ok = 1'b1;
        break;
      end
      p = sclk;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s actual=no sclk fall required=fall within 40 clk", name);
    end
  endtask

  // Monitor: rebuild each frame from the sdo value held just before each shift.
  initial begin : monitor
    logic [7:0] acc;
    int         nbits;
    int         gap;
    logic       prev_sclk;
    logic       prev_sdo;
    exp_t       e;
    acc       = '0;
    nbits     = 0;
    gap       = 0;
    prev_sclk = 1'b0;
    prev_sdo  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      gap++;
      if (rst || load) begin
        acc   = '0;
        nbits = 0;
      end else if (prev_sclk && !sclk) begin
        acc   = {acc[6:0], prev_sdo};
        nbits++;
      end
      if (frame === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=frame pulse word=%0h required=no frame", acc);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("frame%0d_bits", e.tag), nbits, 8);
          if (!e.word_dc) check($sformatf("frame%0d_word", e.tag), 32'(acc), 32'(e.word));
          if (e.gap >= 0) check($sformatf("frame%0d_gap", e.tag), gap, e.gap);
        end
        acc   = '0;
        nbits = 0;
        gap   = 0;
      end
      prev_sclk = sclk;
      prev_sdo  = sdo;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] pat;
    int         first;
    int         tog;
    logic       p;
    logic       fz;
    bit         ok;

    en        = 1'b1;
    load      = 1'b0;
    load_data = '0;
    ser_in    = 1'b0;
    mode      = 2'd0;
    div_val   = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_sdo", 32'(sdo), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);

    // All-ones rotate, div_val=0: sdo stays 1, frame every 16 clk.
    push(1, 8'hFF, 1'b1, -1);
    push(2, 8'hFF, 1'b0, 16);
    push(3, 8'hFF, 1'b0, 16);
    @(negedge clk);
    rst   = 1'b0;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #2;
      if (first == 0 && sclk) first = i;
    end
    // Two synchroniser edges, then the tick at div_val+1.
    check("first_tick_edge", first, 3);
    wait_empty("t1", 200);
    @(negedge clk);
    en = 1'b0;

    // 8'h80 rotate, div_val=3: one 1 then seven 0s per frame, frame every 64 clk.
    div_val   = 24'd3;
    load_data = 8'h80;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push(4, 8'h80, 1'b1, -1);
    push(5, 8'h80, 1'b0, 64);
    push(6, 8'h80, 1'b0, 64);
    en = 1'b1;
    wait_empty("t2", 400);
    @(negedge clk);
    en = 1'b0;

    // Shift-in 1,0,1,1,0,0,1,0 from 8'h00, then rotate out the captured 8'hB2.
    div_val   = 24'd1;
    mode      = 2'd1;
    load_data = 8'h00;
    load      = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    pat    = 8'b1011_0010;
    ser_in = pat[7];
    push(7, 8'h00, 1'b0, -1);
    push(8, 8'hB2, 1'b0, 32);
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_fall("shift_in_edge", ok);
      @(negedge clk);
      if (k < 7) ser_in = pat[6-k];
      else mode = 2'd0;
    end
    wait_empty("t3", 300);
    @(negedge clk);
    en = 1'b0;

    // Mode 2 from 8'h00.
    div_val   = '0;
    mode      = 2'd2;
    load_data = 8'h00;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
`ifdef SPI_PATTERN_LFSR_EN
    // 00 -> 01 -> ... ; frame word equals the state at frame start: 00, 8E, 25,
    // and after 255 states the sequence repeats, so frame 257 shows 8E again.
    push(10, 8'h00, 1'b0, -1);
    push(11, 8'h8E, 1'b0, 16);
    push(12, 8'h25, 1'b0, 16);
    for (int k = 0; k < 253; k++) push(100 + k, 8'h00, 1'b1, 16);
    push(13, 8'h8E, 1'b0, 16);
    en = 1'b1;
    wait_empty("t4_lfsr", 257 * 16 + 100);
    @(negedge clk);
    en = 1'b0;
`else
    // Without the LFSR build, mode 2 rotates.
    push(10, 8'h00, 1'b0, -1);
    push(11, 8'h00, 1'b0, 16);
    en = 1'b1;
    wait_empty("t4_rot0", 100);
    @(negedge clk);
    en        = 1'b0;
    load_data = 8'hC5;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push(12, 8'hC5, 1'b1, -1);
    push(13, 8'hC5, 1'b0, 16);
    en = 1'b1;
    wait_empty("t4_rot1", 100);
    @(negedge clk);
    en = 1'b0;
`endif

    // div_val 100 -> 2 with the counter at 50: tick next edge, then every 3.
    mode    = 2'd3;
    div_val = 24'd100;
    en      = 1'b1;
    p       = sclk;
    tog     = 0;
    repeat (50) begin
      @(posedge clk);
      #2;
      if (sclk != p) tog++;
      p = sclk;
    end
    check("div_no_tick_before_50", tog, 0);
    @(negedge clk);
    div_val = 24'd2;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #2;
      check($sformatf("div_shrink_edge%0d", i), 32'(sclk != p), 32'((i % 3) == 1));
      p = sclk;
    end
    @(negedge clk);
    en = 1'b0;

    // Reset mid-frame: no pulse from the aborted frame, reset values restored.
    mode    = 2'd0;
    div_val = '0;
    en      = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_sdo", 32'(sdo), 32'd1);
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_frame", 32'(frame), 32'd0);
    push(20, 8'hFF, 1'b1, -1);
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    fz = sclk;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      check($sformatf("en_low_sclk%0d", i), 32'(sclk), 32'(fz));
      check($sformatf("en_low_frame%0d", i), 32'(frame), 32'd0);
    end
    @(negedge clk);
    en = 1'b1;
    wait_empty("t6", 200);

    // Load held high: reloads every cycle, sclk keeps running, no shift or frame.
    @(negedge clk);
    load_data = 8'h40;
    load      = 1'b1;
    p         = sclk;
    tog       = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      check($sformatf("load_hold_sdo%0d", i), 32'(sdo), 32'd0);
      check($sformatf("load_hold_frame%0d", i), 32'(frame), 32'd0);
      if (sclk != p) tog++;
      p = sclk;
    end
    check("load_hold_sclk_toggles", tog, 6);
    push(21, 8'h40, 1'b1, -1);
    @(negedge clk);
    load = 1'b0;
    wait_empty("t7", 200);
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_pattern_tx.md
SPI_PATTERN_TX -- requirements
Module: spi_pattern_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning pattern register width in bits (2..32).
REQ-002 SHALL have parameter DIV_W, default 24, meaning divider counter width.
REQ-003 SHALL have parameter TAPS, default 8'hB8, meaning LFSR feedback mask, WIDTH bits.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, run enable.
REQ-007 SHALL have port div_val, input, DIV_W, the half-period of sclk in clk cycles minus 1.
REQ-008 SHALL have port mode, input, 2: 0 rotate, 1 shift-in from ser_in, 2 LFSR, 3 hold.
REQ-009 SHALL have port load, input, 1, synchronous parallel load request (level).
REQ-010 SHALL have port load_data, input, WIDTH, value loaded on load.
REQ-011 SHALL have port ser_in, input, 1, serial input for mode 1.
REQ-012 SHALL have port sclk, output, 1, divided serial clock.
REQ-013 SHALL have port sdo, output, 1, serial data equal to shift register MSB.
REQ-014 SHALL have port frame, output, 1, one-clk pulse at each WIDTH-bit boundary.

Function
REQ-015 Divider SHALL count div_cnt 0..div_val while en=1; tick when div_cnt >= div_val, then div_cnt returns to 0 (covers div_val lowered below div_cnt).
REQ-016 div_val=0 SHALL give a tick every clk cycle (sclk = clk/2).
REQ-017 sclk SHALL toggle on every tick; a shift SHALL occur only on a tick where sclk goes 1->0, so sdo changes on sclk falling edge and is stable at sclk rising edge.
REQ-018 Shift rules: mode 0 next = {r[W-2:0], r[W-1]}; mode 1 next = {r[W-2:0], ser_in}; mode 2 next = {r[W-2:0], ^(r & TAPS)}, with all-zero state forced to next = 1; mode 3 no change.
REQ-019 Bit counter SHALL increment on each shift edge (including mode 3) and wrap WIDTH-1 -> 0; frame SHALL be 1 for exactly the clk cycle following that wrap edge.
REQ-020 load=1 SHALL load load_data and clear bit counter in the same cycle, with priority over any shift; divider and sclk SHALL keep running; load held high SHALL keep reloading every cycle.
REQ-021 en=0 SHALL freeze div_cnt, sclk, shift register and bit counter; frame SHALL be 0; load SHALL still act.
REQ-022 mode changes SHALL take effect at the next shift edge; no register cleared.
REQ-023 Output latency: sdo SHALL reflect shift register MSB combinationally from the register (0 extra cycles).

Reset
REQ-024 rst=1 SHALL asynchronously set shift register to all ones, sdo=1, sclk=0, frame=0, div_cnt=0, bit counter=0.
REQ-025 Reset release SHALL be synchronised internally; first tick SHALL occur div_val+1 cycles after release with en=1.
REQ-026 rst asserted mid-frame SHALL abort the frame with no frame pulse.

Configuration
REQ-027 Macro SPI_PATTERN_LFSR_EN defined SHALL compile in mode 2 LFSR logic per REQ-018.
REQ-028 Without SPI_PATTERN_LFSR_EN, mode 2 SHALL behave as mode 0 rotate and TAPS SHALL be unused.

Structure
REQ-029 Shared package spi_pattern_pkg SHALL hold the mode encoding constants (ROTATE, SHIFT_IN, LFSR, HOLD) and default TAPS constant.
REQ-030 Divider SHALL be a sub-module clk_div_tick (inputs clk, rst, en, div_val; output tick).

Verification
REQ-031 Reset, en=1, div_val=0, mode 0, no load -> sclk period 2 clk, sdo constant 1, frame every 16 clk.
REQ-032 load_data=8'h80, mode 0, div_val=3 -> sdo 1 for one sclk period then 0 for seven, repeat; frame every 64 clk.
REQ-033 mode 1, load 8'h00, ser_in pattern 1,0,1,1,0,0,1,0 -> after 8 shift edges register = 8'hB2, frame pulses once.
REQ-034 mode 2 (macro defined), load 8'h00 -> next state 8'h01, then sequence has period 255 with TAPS=8'hB8; macro undefined -> rotate behaviour.
REQ-035 div_val changed 100->2 while div_cnt=50 -> tick next cycle, then period 3 clk.
REQ-036 rst pulsed mid-frame and en toggled low for 10 cycles -> registers at reset values, no frame pulse, sclk frozen while en=0.
